cirno9_sram_arb: RTL

CIRNO9_SRAM_ARB -- requirements
Module: cirno9_sram_arb

---
 rtl/cirno9_sram_arb_pkg.sv | 17 +
 rtl/cirno9_sram_arb_pri.sv | 39 +++
 rtl/cirno9_sram_arb.sv | 107 ++++++++++
 3 files changed

// File: rtl/cirno9_sram_arb_pkg.sv
// Shared definitions for the cirno9 SRAM arbiter: response owner tags, counter type and
// default parameter values.
package cirno9_sram_arb_pkg;

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnIfu  = 2'd1,
        OwnLsu  = 2'd2
    } owner_e;

    localparam int unsigned AddrWidthDefault = 14;
    localparam int unsigned StarveMaxDefault = 4;
    localparam int unsigned StarveCntWidth   = 3;

    typedef logic [StarveCntWidth-1:0] starve_cnt_t;

endpackage

// File: rtl/cirno9_sram_arb_pri.sv
// Combinational grant selection between IFU and LSU, with the next value of the
// starvation counter that lets the IFU through after STARVE_MAX lost conflicts.
module cirno9_sram_arb_pri
    import cirno9_sram_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = StarveMaxDefault
) (
    input  logic        ifu_vld,
    input  logic        ifu_flush,
    input  logic        lsu_vld,
    input  starve_cnt_t starve_cnt,
    output logic        ifu_gnt,
    output logic        lsu_gnt,
    output starve_cnt_t starve_cnt_d
);

    localparam starve_cnt_t StarveMaxCnt = starve_cnt_t'(STARVE_MAX);

    logic ifu_ok;
    logic starved;

    always_comb begin
        // A flushing IFU cannot be granted, so it does not contend either.
        ifu_ok  = ifu_vld & ~ifu_flush;
        starved = (starve_cnt >= StarveMaxCnt);
        lsu_gnt = lsu_vld & ~(ifu_ok & starved);
        ifu_gnt = ifu_ok & ~lsu_gnt;
    end

    always_comb begin
        starve_cnt_d = starve_cnt;
        if (ifu_gnt) begin
            starve_cnt_d = '0;
        end else if (lsu_gnt && ifu_ok && !starved) begin
            starve_cnt_d = starve_cnt + starve_cnt_t'(1);
        end
    end

endmodule

// File: rtl/cirno9_sram_arb.sv
// Single-port SRAM arbiter between instruction fetch and load/store. One access per cycle,
// responses return one cycle after the grant, routed by a registered owner tag.
module cirno9_sram_arb
    import cirno9_sram_arb_pkg::*;
#(
    parameter int unsigned AW         = AddrWidthDefault,
    parameter int unsigned STARVE_MAX = StarveMaxDefault
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ifu_req_vld,
    output logic          ifu_req_rdy,
    input  logic [31:0]   ifu_req_addr,
    input  logic          ifu_flush,
    output logic          ifu_rsp_vld,
    output logic [31:0]   ifu_rsp_data,
    input  logic          lsu_req_vld,
    output logic          lsu_req_rdy,
    input  logic [31:0]   lsu_req_addr,
    input  logic          lsu_req_wen,
    input  logic [31:0]   lsu_req_wdata,
    input  logic [3:0]    lsu_req_wstrb,
    output logic          lsu_rsp_vld,
    output logic [31:0]   lsu_rsp_data,
    output logic          sram_cs,
    output logic          sram_we,
    output logic [3:0]    sram_wem,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_din,
    input  logic [31:0]   sram_dout
);

    owner_e      owner_q, owner_d;
    logic        store_q, store_d;
    starve_cnt_t starve_cnt_q, starve_cnt_d;

    logic ifu_gnt, lsu_gnt;
    logic ifu_hs, lsu_hs, lsu_store;

    // Byte-offset and out-of-range address bits are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ifu_req_addr[31:AW+2], ifu_req_addr[1:0],
                                lsu_req_addr[31:AW+2], lsu_req_addr[1:0]};

    cirno9_sram_arb_pri #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pri (
        .ifu_vld      (ifu_req_vld),
        .ifu_flush    (ifu_flush),
        .lsu_vld      (lsu_req_vld),
        .starve_cnt   (starve_cnt_q),
        .ifu_gnt      (ifu_gnt),
        .lsu_gnt      (lsu_gnt),
        .starve_cnt_d (starve_cnt_d)
    );

    // Request side: grants are masked by rst_n so everything is quiet while in reset.
    always_comb begin
        ifu_hs      = rst_n & ifu_gnt;
        lsu_hs      = rst_n & lsu_gnt;
        lsu_store   = lsu_hs & lsu_req_wen;
        ifu_req_rdy = ifu_hs;
        lsu_req_rdy = lsu_hs;
        sram_cs     = ifu_hs | lsu_hs;
        sram_we     = lsu_store;
        sram_wem    = lsu_store ? lsu_req_wstrb : 4'b0000;
        sram_din    = lsu_store ? lsu_req_wdata : 32'h0;
        sram_addr   = '0;
        if (lsu_hs) begin
            sram_addr = lsu_req_addr[AW+1:2];
        end else if (ifu_hs) begin
            sram_addr = ifu_req_addr[AW+1:2];
        end
    end

    always_comb begin
        owner_d = OwnNone;
        store_d = 1'b0;
        if (lsu_hs) begin
            owner_d = OwnLsu;
            store_d = lsu_req_wen;
        end else if (ifu_hs) begin
            owner_d = OwnIfu;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= OwnNone;
            store_q      <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            owner_q      <= owner_d;
            store_q      <= store_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Response side: a flush in the response cycle drops the fetch data.
    always_comb begin
        ifu_rsp_vld  = (owner_q == OwnIfu) & ~ifu_flush;
        ifu_rsp_data = ifu_rsp_vld ? sram_dout : 32'h0;
        lsu_rsp_vld  = (owner_q == OwnLsu);
        lsu_rsp_data = (lsu_rsp_vld && !store_q) ? sram_dout : 32'h0;
    end

endmodule
